// File: rtl/tune_sequencer.sv
// Note-table music sequencer: fetches table words, plays each tone for its
// programmed duration, inserts a silent gap, and stops/loops at the END word.
module tune_sequencer #(
  parameter int ADDR_W  = 7,
  parameter int UNIT_MS = 10,
  parameter int GAP_MS  = 20
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [15:0]       ticks_per_milli,
  input  logic              start,
  input  logic              stop,
  input  logic              loop,
  output logic [ADDR_W-1:0] note_addr,
  input  logic [15:0]       note_data,
  output logic [9:0]        tone_half_period,
  output logic              tone_en,
  output logic [7:0]        led,
  output logic              busy,
  output logic              done
);

  localparam int MS_W = 37;
  localparam logic [MS_W-1:0] UNIT_T = MS_W'(UNIT_MS);
  localparam logic [MS_W-1:0] GAP_T  = MS_W'(GAP_MS);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    LOAD  = 3'd2,
    PLAY  = 3'd3,
    GAP   = 3'd4
  } state_t;

  state_t            state_r, state_s;
  logic [ADDR_W-1:0] addr_r, addr_s;
  logic [9:0]        hp_r, hp_s;
  logic              en_r, en_s;
  logic [4:0]        dur_r, dur_s;
  logic [15:0]       presc_r, presc_s;
  logic [MS_W-1:0]   ms_r, ms_s;
  logic              done_r, done_s;
  logic [7:0]        led_r, led_s;
  logic              busy_r;
  logic [15:0]       t_m1_s;
  logic              ms_tick_s;
  logic [MS_W-1:0]   play_target_s;
  logic [6:0]        addr7_s;

  // Timebase terminal count and full-width note length in ms.
  always_comb begin
    t_m1_s        = (ticks_per_milli == 16'd0) ? 16'd0 : (ticks_per_milli - 16'd1);
    ms_tick_s     = (presc_r >= t_m1_s);
    play_target_s = MS_W'(dur_r) * UNIT_T;
  end

  // Next-state and next-output logic; stop dominates every decision.
  always_comb begin
    state_s = state_r;
    addr_s  = addr_r;
    hp_s    = hp_r;
    en_s    = en_r;
    dur_s   = dur_r;
    presc_s = 16'd0;
    ms_s    = '0;
    done_s  = 1'b0;
    if (stop) begin
      state_s = IDLE;
      en_s    = 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            state_s = FETCH;
            addr_s  = '0;
          end else begin
            state_s = IDLE;
          end
        end
        FETCH: state_s = LOAD;
        LOAD: begin
          dur_s = note_data[14:10];
          if (note_data[15]) begin
            if (loop) begin
              addr_s  = '0;
              state_s = FETCH;
            end else begin
              done_s  = 1'b1;
              state_s = IDLE;
            end
          end else if (note_data[14:10] == 5'd0) begin
            addr_s  = addr_r + ADDR_W'(1'b1);
            state_s = FETCH;
          end else begin
            hp_s    = note_data[9:0];
            en_s    = (note_data[9:0] != 10'd0);
            state_s = PLAY;
          end
        end
        PLAY: begin
          if (!ms_tick_s) begin
            presc_s = presc_r + 16'd1;
            ms_s    = ms_r;
          end else if ((ms_r + MS_W'(1'b1)) >= play_target_s) begin
            en_s    = 1'b0;
            addr_s  = addr_r + ADDR_W'(1'b1);
            state_s = (GAP_MS == 0) ? FETCH : GAP;
          end else begin
            ms_s = ms_r + MS_W'(1'b1);
          end
        end
        GAP: begin
          if (!ms_tick_s) begin
            presc_s = presc_r + 16'd1;
            ms_s    = ms_r;
          end else if ((ms_r + MS_W'(1'b1)) >= GAP_T) begin
            state_s = FETCH;
          end else begin
            ms_s = ms_r + MS_W'(1'b1);
          end
        end
        default: begin
          state_s = IDLE;
          en_s    = 1'b0;
        end
      endcase
    end
    addr7_s = 7'(addr_s);
    led_s   = (state_s == PLAY) ? {en_s, addr7_s} : 8'd0;
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= IDLE;
      addr_r  <= '0;
      hp_r    <= 10'd0;
      en_r    <= 1'b0;
      dur_r   <= 5'd0;
      presc_r <= 16'd0;
      ms_r    <= '0;
      done_r  <= 1'b0;
      led_r   <= 8'd0;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      addr_r  <= addr_s;
      hp_r    <= hp_s;
      en_r    <= en_s;
      dur_r   <= dur_s;
      presc_r <= presc_s;
      ms_r    <= ms_s;
      done_r  <= done_s;
      led_r   <= led_s;
      busy_r  <= (state_s != IDLE);
    end
  end

  assign note_addr        = addr_r;
  assign tone_half_period = hp_r;
  assign tone_en          = en_r;
  assign led              = led_r;
  assign busy             = busy_r;
  assign done             = done_r;

endmodule

// File: tb/tb_tune_sequencer.sv
// Randomized self-checking bench for tune_sequencer using a per-cycle
// timeline model built from the note table.
module tb_tune_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, start, start2, stop, loop;
  logic [15:0] tpm;
  logic [6:0]  addr1;
  logic [1:0]  addr2;
  logic [15:0] data1, data2;
  logic [9:0]  hp1, hp2;
  logic        en1, en2, busy1, busy2, done1, done2;
  logic [7:0]  led1, led2;
  logic [15:0] mem1 [128];
  logic [15:0] mem2 [4];

  tune_sequencer #(.ADDR_W(7), .UNIT_MS(10), .GAP_MS(1)) dut (
    .clk(clk), .rst_n(rst_n), .ticks_per_milli(tpm), .start(start), .stop(stop),
    .loop(loop), .note_addr(addr1), .note_data(data1), .tone_half_period(hp1),
    .tone_en(en1), .led(led1), .busy(busy1), .done(done1));

  tune_sequencer #(.ADDR_W(2), .UNIT_MS(1), .GAP_MS(0)) dut2 (
    .clk(clk), .rst_n(rst_n), .ticks_per_milli(tpm), .start(start2), .stop(stop),
    .loop(loop), .note_addr(addr2), .note_data(data2), .tone_half_period(hp2),
    .tone_en(en2), .led(led2), .busy(busy2), .done(done2));

  // Registered note memories: data follows the address by one cycle.
  always @(posedge clk) begin
    data1 <= mem1[addr1];
    data2 <= mem2[addr2];
  end

  typedef struct {
    logic       en;
    logic [9:0] hp;
    logic [6:0] addr;
    logic [7:0] led;
    logic       busy;
    logic       done;
    logic       lp;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          passed = 0;
  logic [27:0] got, want;

  function automatic logic [15:0] word_at(input int aw, input int a);
    return (aw == 2) ? mem2[a] : mem1[a];
  endfunction

  function automatic void push_e(input logic en, input logic [9:0] hp, input int addr,
                                 input logic busy, input logic dn, input logic lp, input logic play);
    exp_t e;
    e.en = en; e.hp = hp; e.addr = 7'(addr); e.busy = busy; e.done = dn; e.lp = lp;
    e.led = play ? {en, 7'(addr)} : 8'd0;
    exp_q.push_back(e);
  endfunction

  // Timeline of every cycle after the start edge, word by word.
  task automatic build_trace(input int aw, input int unit, input int gap, input int t,
                             input int n_loops, input int max_len);
    int addr = 0;
    int ends = 0;
    int dur;
    int nw = 1 << aw;
    logic [9:0] hp = 10'd0;
    logic [15:0] w;
    logic lp;
    exp_q.delete();
    while (exp_q.size() < max_len) begin
      w = word_at(aw, addr);
      lp = (ends < n_loops);
      dur = int'(w[14:10]);
      push_e(1'b0, hp, addr, 1'b1, 1'b0, lp, 1'b0);
      push_e(1'b0, hp, addr, 1'b1, 1'b0, lp, 1'b0);
      if (w[15]) begin
        ends++;
        if (lp) addr = 0;
        else begin
          push_e(1'b0, hp, addr, 1'b0, 1'b1, lp, 1'b0);
          break;
        end
      end else if (dur == 0) begin
        addr = (addr + 1) % nw;
      end else begin
        hp = w[9:0];
        for (int k = 0; k < dur * unit * t; k++) push_e(hp != 10'd0, hp, addr, 1'b1, 1'b0, lp, 1'b1);
        addr = (addr + 1) % nw;
        for (int k = 0; k < gap * t; k++) push_e(1'b0, hp, addr, 1'b1, 1'b0, lp, 1'b0);
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; start = 1'b0; start2 = 1'b0; stop = 1'b0; loop = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic kick(input bit second, input bit hold);
    @(negedge clk);
    if (second) start2 = 1'b1; else start = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) begin
      start = 1'b0;
      start2 = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b1; start2 = 1'b0; stop = 1'b0; loop = 1'b0; tpm = 16'd1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if ({en1, hp1, addr1, led1, busy1, done1} !== 28'd0) $display("FAIL reset_outputs cyc %0d got %h want 0", i, {en1, hp1, addr1, led1, busy1, done1});
      else passed++;
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({busy1, addr1} !== 8'h80) $display("FAIL reset_first_start got busy=%b addr=%0d want busy=1 addr=0", busy1, addr1);
    else passed++;
    start = 1'b0;
  endtask

  task automatic test_single_note();
    int n_en = 0;
    do_reset();
    tpm = 16'd4;
    mem1[0] = 16'h0864; mem1[1] = 16'h8000;
    build_trace(7, 10, 1, 4, 0, 1000);
    kick(1'b0, 1'b0);
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge clk);
      loop = exp_q[i].lp;
      if (en1) n_en++;
      got = {en1, hp1, addr1, led1, busy1, done1};
      want = {exp_q[i].en, exp_q[i].hp, exp_q[i].addr, exp_q[i].led, exp_q[i].busy, exp_q[i].done};
      checks++;
      if (got !== want) begin $display("FAIL single_note cyc %0d got %h want %h", i, got, want); break; end
      else passed++;
    end
    checks++;
    if (n_en !== 80) $display("FAIL single_note_len got %0d want 80", n_en);
    else passed++;
  endtask

  task automatic test_rest_skip();
    do_reset();
    tpm = 16'd4;
    mem1[0] = 16'h0800; mem1[1] = 16'h0032; mem1[2] = 16'h0432; mem1[3] = 16'h8000;
    build_trace(7, 10, 1, 4, 0, 1000);
    kick(1'b0, 1'b0);
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge clk);
      loop = exp_q[i].lp;
      got = {en1, hp1, addr1, led1, busy1, done1};
      want = {exp_q[i].en, exp_q[i].hp, exp_q[i].addr, exp_q[i].led, exp_q[i].busy, exp_q[i].done};
      checks++;
      if (got !== want) begin $display("FAIL rest_skip cyc %0d got %h want %h", i, got, want); break; end
      else passed++;
    end
  endtask

  task automatic test_loop();
    int n_done = 0;
    do_reset();
    tpm = 16'd1;
    mem1[0] = 16'h041E; mem1[1] = 16'h0440; mem1[2] = 16'h8000;
    build_trace(7, 10, 1, 1, 2, 1000);
    kick(1'b0, 1'b0);
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge clk);
      loop = exp_q[i].lp;
      if (done1) n_done++;
      got = {en1, hp1, addr1, led1, busy1, done1};
      want = {exp_q[i].en, exp_q[i].hp, exp_q[i].addr, exp_q[i].led, exp_q[i].busy, exp_q[i].done};
      checks++;
      if (got !== want) begin $display("FAIL loop cyc %0d got %h want %h", i, got, want); break; end
      else passed++;
    end
    checks++;
    if (n_done !== 1) $display("FAIL loop_done_count got %0d want 1", n_done);
    else passed++;
  endtask

  task automatic test_stop();
    int k = 0;
    do_reset();
    tpm = 16'd2;
    mem1[0] = 16'h0464; mem1[1] = 16'h0832; mem1[2] = 16'h8000;
    build_trace(7, 10, 1, 2, 0, 1000);
    while (k < exp_q.size() && !(exp_q[k].addr == 7'd1 && exp_q[k].en)) k++;
    k = k + 10;
    kick(1'b0, 1'b0);
    for (int i = 0; i <= k; i++) begin
      @(negedge clk);
      got = {en1, hp1, addr1, led1, busy1, done1};
      want = {exp_q[i].en, exp_q[i].hp, exp_q[i].addr, exp_q[i].led, exp_q[i].busy, exp_q[i].done};
      checks++;
      if (got !== want) begin $display("FAIL stop_prefix cyc %0d got %h want %h", i, got, want); break; end
      else passed++;
    end
    stop = 1'b1; start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if ({en1, addr1, led1, busy1, done1} !== {1'b0, exp_q[k].addr, 8'd0, 1'b0, 1'b0})
        $display("FAIL stop_idle cyc %0d got en=%b addr=%0d led=%h busy=%b done=%b want addr=%0d others 0", i, en1, addr1, led1, busy1, done1, exp_q[k].addr);
      else passed++;
    end
    stop = 1'b0; start = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    tpm = 16'd1;
    mem1[0] = 16'h0C07; mem1[1] = 16'h8000;
    kick(1'b0, 1'b0);
    repeat (7) @(negedge clk);
    checks++;
    if (en1 !== 1'b1) $display("FAIL reset_mid_playing got en=%b want 1", en1);
    else passed++;
    rst_n = 1'b0; start = 1'b1;
    @(negedge clk);
    checks++;
    if ({en1, hp1, addr1, led1, busy1, done1} !== 28'd0) $display("FAIL reset_mid got %h want 0", {en1, hp1, addr1, led1, busy1, done1});
    else passed++;
    rst_n = 1'b1; start = 1'b0;
  endtask

  task automatic test_tpm_zero();
    int n_en = 0;
    do_reset();
    tpm = 16'd0;
    mem1[0] = 16'h0C07; mem1[1] = 16'h8000;
    build_trace(7, 10, 1, 1, 0, 1000);
    kick(1'b0, 1'b0);
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge clk);
      loop = exp_q[i].lp;
      if (en1) n_en++;
      got = {en1, hp1, addr1, led1, busy1, done1};
      want = {exp_q[i].en, exp_q[i].hp, exp_q[i].addr, exp_q[i].led, exp_q[i].busy, exp_q[i].done};
      checks++;
      if (got !== want) begin $display("FAIL tpm_zero cyc %0d got %h want %h", i, got, want); break; end
      else passed++;
    end
    checks++;
    if (n_en !== 30) $display("FAIL tpm_zero_len got %0d want 30", n_en);
    else passed++;
  endtask

  task automatic test_wrap();
    int wraps = 0;
    logic [1:0] prev = 2'd0;
    do_reset();
    tpm = 16'd2;
    for (int i = 0; i < 4; i++) mem2[i] = {1'b0, 5'($urandom_range(1, 3)), 10'($urandom_range(1, 1023))};
    build_trace(2, 1, 0, 2, 0, 80);
    kick(1'b1, 1'b0);
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge clk);
      if (prev == 2'd3 && addr2 == 2'd0) wraps++;
      prev = addr2;
      got = {en2, hp2, 5'd0, addr2, led2, busy2, done2};
      want = {exp_q[i].en, exp_q[i].hp, exp_q[i].addr, exp_q[i].led, exp_q[i].busy, exp_q[i].done};
      checks++;
      if (got !== want) begin $display("FAIL wrap cyc %0d got %h want %h", i, got, want); break; end
      else passed++;
    end
    checks++;
    if (wraps < 1) $display("FAIL wrap_seen got %0d want >=1", wraps);
    else passed++;
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
  endtask

  task automatic test_random();
    int n, t, nl;
    for (int r = 0; r < 4; r++) begin
      do_reset();
      t = $urandom_range(1, 3);
      tpm = 16'(t);
      n = $urandom_range(2, 6);
      for (int i = 0; i < n; i++)
        mem1[i] = {1'b0, 5'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0) ? 10'd0 : 10'($urandom_range(1, 1023))};
      mem1[n] = 16'h8000;
      nl = $urandom_range(0, 1);
      build_trace(7, 10, 1, t, nl, 3000);
      kick(1'b0, 1'b0);
      for (int i = 0; i < exp_q.size(); i++) begin
        @(negedge clk);
        loop = exp_q[i].lp;
        got = {en1, hp1, addr1, led1, busy1, done1};
        want = {exp_q[i].en, exp_q[i].hp, exp_q[i].addr, exp_q[i].led, exp_q[i].busy, exp_q[i].done};
        checks++;
        if (got !== want) begin $display("FAIL random r%0d cyc %0d got %h want %h", r, i, got, want); break; end
        else passed++;
      end
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    tpm = 16'd1;
    mem1[0] = 16'h0405; mem1[1] = 16'h8000;
    build_trace(7, 10, 1, 1, 0, 1000);
    kick(1'b0, 1'b1);
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge clk);
      loop = exp_q[i].lp;
      got = {en1, hp1, addr1, led1, busy1, done1};
      want = {exp_q[i].en, exp_q[i].hp, exp_q[i].addr, exp_q[i].led, exp_q[i].busy, exp_q[i].done};
      checks++;
      if (got !== want) begin $display("FAIL back_to_back cyc %0d got %h want %h", i, got, want); break; end
      else passed++;
    end
    @(negedge clk);
    checks++;
    if ({busy1, done1, addr1} !== 9'h100) $display("FAIL back_to_back_restart got busy=%b done=%b addr=%0d want busy=1 done=0 addr=0", busy1, done1, addr1);
    else passed++;
    start = 1'b0; stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_note();
    test_rest_skip();
    test_loop();
    test_stop();
    test_reset_mid();
    test_tpm_zero();
    test_wrap();
    test_random();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
